// File: rtl/mrd_rdx_gather.sv
// Serial-to-lane gather for the mixed-radix DFT stages: packs radix (2..5) samples into a 5-lane vector.
// Optional MRD_GATHER_ERR_EN adds the err_drop pulse for partial groups discarded by in_sop.

module mrd_rdx_gather_lane #(
  parameter int W = 30
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         wr_en,
  input  logic         emit,
  input  logic         keep,
  input  logic         byp,
  input  logic [W-1:0] din_re,
  input  logic [W-1:0] din_im,
  output logic [W-1:0] dout_re,
  output logic [W-1:0] dout_im
);
  logic [W-1:0] stg_re, stg_im;

  always_ff @(posedge clk) begin
    if (rst) begin
      stg_re  <= '0;
      stg_im  <= '0;
      dout_re <= '0;
      dout_im <= '0;
    end else begin
      if (wr_en) begin
        stg_re <= din_re;
        stg_im <= din_im;
      end
      // The completing sample bypasses staging so the vector leaves one edge after it.
      if (emit) begin
        dout_re <= !keep ? '0 : byp ? din_re : stg_re;
        dout_im <= !keep ? '0 : byp ? din_im : stg_im;
      end
    end
  end
endmodule

module mrd_rdx_gather #(
  parameter int wDataInOut = 30,
  localparam int NUM_LANES = 5
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  in_val,
  input  logic                                  in_sop,
  input  logic [2:0]                            radix,
  input  logic [wDataInOut-1:0]                 din_real,
  input  logic [wDataInOut-1:0]                 din_imag,
  output logic                                  out_val,
  output logic [2:0]                            out_radix,
  output logic [NUM_LANES-1:0][wDataInOut-1:0]  dout_real,
  output logic [NUM_LANES-1:0][wDataInOut-1:0]  dout_imag
`ifdef MRD_GATHER_ERR_EN
  ,
  output logic                                  err_drop
`endif
);
  logic [2:0] cnt, r_lat;
  logic [2:0] r_coerced, r_eff, lane;
  logic       start, done;

  // A sop sample always opens a new group at lane 0; radix is only sampled then.
  always_comb begin
    r_coerced = (radix < 3'd2 || radix > 3'd5) ? 3'd5 : radix;
    start     = in_val && (in_sop || cnt == 3'd0);
    lane      = in_sop ? 3'd0 : cnt;
    r_eff     = start ? r_coerced : r_lat;
    done      = in_val && (lane == r_eff - 3'd1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt       <= 3'd0;
      r_lat     <= 3'd5;
      out_val   <= 1'b0;
      out_radix <= 3'd0;
    end else begin
      out_val <= done;
      if (in_val) begin
        if (start) r_lat <= r_coerced;
        cnt <= done ? 3'd0 : lane + 3'd1;
      end
      if (done) out_radix <= r_eff;
    end
  end

`ifdef MRD_GATHER_ERR_EN
  always_ff @(posedge clk) begin
    if (rst) err_drop <= 1'b0;
    else     err_drop <= in_val && in_sop && cnt != 3'd0;
  end
`endif

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    mrd_rdx_gather_lane #(.W(wDataInOut)) u_lane (
      .clk     (clk),
      .rst     (rst),
      .wr_en   (in_val && lane == 3'(i)),
      .emit    (done),
      .keep    (3'(i) < r_eff),
      .byp     (lane == 3'(i)),
      .din_re  (din_real),
      .din_im  (din_imag),
      .dout_re (dout_real[i]),
      .dout_im (dout_imag[i])
    );
  end
endmodule

// File: tb/tb_mrd_rdx_gather.sv
// Directed bench for mrd_rdx_gather: one task per scenario with hand-computed lane vectors.
module tb_mrd_rdx_gather;
  localparam int W = 30;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               in_val = 1'b0;
  logic               in_sop = 1'b0;
  logic [2:0]         radix = 3'd0;
  logic [W-1:0]       din_real = '0;
  logic [W-1:0]       din_imag = '0;
  logic               out_val;
  logic [2:0]         out_radix;
  logic [4:0][W-1:0]  dout_real;
  logic [4:0][W-1:0]  dout_imag;
`ifdef MRD_GATHER_ERR_EN
  logic               err_drop;
  int                 errs = 0;
`endif

  int total = 0;
  int bad = 0;
  int strobes = 0;
  int s0;
  int er[5];
  int ei[5];

  mrd_rdx_gather #(.wDataInOut(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_val    (in_val),
    .in_sop    (in_sop),
    .radix     (radix),
    .din_real  (din_real),
    .din_imag  (din_imag),
    .out_val   (out_val),
    .out_radix (out_radix),
    .dout_real (dout_real),
    .dout_imag (dout_imag)
`ifdef MRD_GATHER_ERR_EN
    ,
    .err_drop  (err_drop)
`endif
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (out_val === 1'b1) strobes++;
`ifdef MRD_GATHER_ERR_EN
    if (err_drop === 1'b1) errs++;
`endif
  end

  task automatic send(input int re, input int im, input logic sop);
    in_val   = 1'b1;
    in_sop   = sop;
    din_real = W'(re);
    din_imag = W'(im);
    @(posedge clk); #1;
    in_val = 1'b0;
    in_sop = 1'b0;
  endtask

  task automatic idle(input int n);
    in_val = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    idle(2);
    total++; if (out_val !== 1'b0) begin bad++; $display("FAIL reset_out_val got=%b want=0", out_val); end
    total++; if (out_radix !== 3'd0) begin bad++; $display("FAIL reset_out_radix got=%0d want=0", out_radix); end
    for (int i = 0; i < 5; i++) begin
      total++;
      if (dout_real[i] !== '0 || dout_imag[i] !== '0) begin
        bad++; $display("FAIL reset_lane%0d got=%h/%h want=0/0", i, dout_real[i], dout_imag[i]);
      end
    end
`ifdef MRD_GATHER_ERR_EN
    total++; if (err_drop !== 1'b0) begin bad++; $display("FAIL reset_err_drop got=%b want=0", err_drop); end
`endif
    rst = 1'b0;
    idle(1);
  endtask

  task automatic test_radix3;
    s0 = strobes;
    radix = 3'd3;
    send(1, -1, 1'b1);
    send(2, -2, 1'b0);
    total++; if (out_val !== 1'b0) begin bad++; $display("FAIL r3_early got=%b want=0", out_val); end
    send(3, -3, 1'b0);
    er = '{1, 2, 3, 0, 0}; ei = '{-1, -2, -3, 0, 0};
    total++; if (out_val !== 1'b1) begin bad++; $display("FAIL r3_strobe got=%b want=1", out_val); end
    total++; if (out_radix !== 3'd3) begin bad++; $display("FAIL r3_radix got=%0d want=3", out_radix); end
    for (int i = 0; i < 5; i++) begin
      total++;
      if (dout_real[i] !== W'(er[i]) || dout_imag[i] !== W'(ei[i])) begin
        bad++; $display("FAIL r3_lane%0d got=%h/%h want=%h/%h", i, dout_real[i], dout_imag[i], W'(er[i]), W'(ei[i]));
      end
    end
    idle(1);
    total++; if (out_val !== 1'b0) begin bad++; $display("FAIL r3_one_cycle got=%b want=0", out_val); end
    total++; if (strobes - s0 !== 1) begin bad++; $display("FAIL r3_count got=%0d want=1", strobes - s0); end
  endtask

  task automatic test_radix5_gaps;
    s0 = strobes;
    radix = 3'd5;
    for (int k = 1; k <= 5; k++) begin
      send(10 * k, -10 * k, k == 1);
      if (k < 5) idle(2);
    end
    er = '{10, 20, 30, 40, 50}; ei = '{-10, -20, -30, -40, -50};
    total++; if (out_val !== 1'b1) begin bad++; $display("FAIL r5_strobe got=%b want=1", out_val); end
    total++; if (out_radix !== 3'd5) begin bad++; $display("FAIL r5_radix got=%0d want=5", out_radix); end
    for (int i = 0; i < 5; i++) begin
      total++;
      if (dout_real[i] !== W'(er[i]) || dout_imag[i] !== W'(ei[i])) begin
        bad++; $display("FAIL r5_lane%0d got=%h/%h want=%h/%h", i, dout_real[i], dout_imag[i], W'(er[i]), W'(ei[i]));
      end
    end
    idle(1);
    total++; if (strobes - s0 !== 1) begin bad++; $display("FAIL r5_count got=%0d want=1", strobes - s0); end
  endtask

  task automatic test_radix_change;
    s0 = strobes;
    radix = 3'd2;
    send(7, 8, 1'b1);
    radix = 3'd7;
    send(9, 10, 1'b0);
    er = '{7, 9, 0, 0, 0}; ei = '{8, 10, 0, 0, 0};
    total++; if (out_val !== 1'b1) begin bad++; $display("FAIL rchg_strobe got=%b want=1", out_val); end
    total++; if (out_radix !== 3'd2) begin bad++; $display("FAIL rchg_radix got=%0d want=2", out_radix); end
    for (int i = 0; i < 5; i++) begin
      total++;
      if (dout_real[i] !== W'(er[i]) || dout_imag[i] !== W'(ei[i])) begin
        bad++; $display("FAIL rchg_lane%0d got=%h/%h want=%h/%h", i, dout_real[i], dout_imag[i], W'(er[i]), W'(ei[i]));
      end
    end
    // next group picks up radix 7, coerced to 5
    for (int k = 1; k <= 4; k++) send(k, k + 100, 1'b0);
    total++; if (out_val !== 1'b0) begin bad++; $display("FAIL coerce_early got=%b want=0", out_val); end
    send(5, 105, 1'b0);
    total++; if (out_val !== 1'b1) begin bad++; $display("FAIL coerce_strobe got=%b want=1", out_val); end
    total++; if (out_radix !== 3'd5) begin bad++; $display("FAIL coerce_radix got=%0d want=5", out_radix); end
    total++; if (dout_real[4] !== W'(5) || dout_imag[4] !== W'(105)) begin
      bad++; $display("FAIL coerce_lane4 got=%h/%h want=5/105", dout_real[4], dout_imag[4]);
    end
    idle(1);
    total++; if (strobes - s0 !== 2) begin bad++; $display("FAIL rchg_count got=%0d want=2", strobes - s0); end
  endtask

  task automatic test_resync;
    s0 = strobes;
`ifdef MRD_GATHER_ERR_EN
    int e0 = errs;
`endif
    radix = 3'd4;
    send(100, -100, 1'b1);
    send(101, -101, 1'b0);
    send(200, -200, 1'b1);
    total++; if (out_val !== 1'b0) begin bad++; $display("FAIL resync_no_strobe got=%b want=0", out_val); end
`ifdef MRD_GATHER_ERR_EN
    total++; if (err_drop !== 1'b1) begin bad++; $display("FAIL resync_err_drop got=%b want=1", err_drop); end
`endif
    send(201, -201, 1'b0);
    send(202, -202, 1'b0);
    total++; if (out_val !== 1'b0) begin bad++; $display("FAIL resync_early got=%b want=0", out_val); end
    send(203, -203, 1'b0);
    er = '{200, 201, 202, 203, 0}; ei = '{-200, -201, -202, -203, 0};
    total++; if (out_val !== 1'b1) begin bad++; $display("FAIL resync_strobe got=%b want=1", out_val); end
    total++; if (out_radix !== 3'd4) begin bad++; $display("FAIL resync_radix got=%0d want=4", out_radix); end
    for (int i = 0; i < 5; i++) begin
      total++;
      if (dout_real[i] !== W'(er[i]) || dout_imag[i] !== W'(ei[i])) begin
        bad++; $display("FAIL resync_lane%0d got=%h/%h want=%h/%h", i, dout_real[i], dout_imag[i], W'(er[i]), W'(ei[i]));
      end
    end
    idle(1);
    total++; if (strobes - s0 !== 1) begin bad++; $display("FAIL resync_count got=%0d want=1", strobes - s0); end
`ifdef MRD_GATHER_ERR_EN
    total++; if (errs - e0 !== 1) begin bad++; $display("FAIL resync_err_count got=%0d want=1", errs - e0); end
`endif
  endtask

  task automatic test_reset_mid;
    s0 = strobes;
    radix = 3'd3;
    // reset coincides with the completing sample
    send(1, 1, 1'b1);
    send(2, 2, 1'b0);
    rst = 1'b1;
    send(3, 3, 1'b0);
    rst = 1'b0;
    total++; if (out_val !== 1'b0) begin bad++; $display("FAIL rstc_strobe got=%b want=0", out_val); end
    total++; if (dout_real[0] !== '0 || out_radix !== 3'd0) begin
      bad++; $display("FAIL rstc_outputs got=%h/%0d want=0/0", dout_real[0], out_radix);
    end
    // reset after 2 of 3 samples, then fresh samples without sop
    send(4, 4, 1'b1);
    send(5, 5, 1'b0);
    rst = 1'b1;
    idle(1);
    total++; if (out_val !== 1'b0 || out_radix !== 3'd0) begin
      bad++; $display("FAIL rstm_ctrl got=%b/%0d want=0/0", out_val, out_radix);
    end
    rst = 1'b0;
    send(31, -31, 1'b0);
    send(32, -32, 1'b0);
    total++; if (out_val !== 1'b0) begin bad++; $display("FAIL rstm_early got=%b want=0", out_val); end
    send(33, -33, 1'b0);
    er = '{31, 32, 33, 0, 0}; ei = '{-31, -32, -33, 0, 0};
    total++; if (out_val !== 1'b1 || out_radix !== 3'd3) begin
      bad++; $display("FAIL rstm_strobe got=%b/%0d want=1/3", out_val, out_radix);
    end
    for (int i = 0; i < 5; i++) begin
      total++;
      if (dout_real[i] !== W'(er[i]) || dout_imag[i] !== W'(ei[i])) begin
        bad++; $display("FAIL rstm_lane%0d got=%h/%h want=%h/%h", i, dout_real[i], dout_imag[i], W'(er[i]), W'(ei[i]));
      end
    end
    idle(1);
    total++; if (strobes - s0 !== 1) begin bad++; $display("FAIL rstm_count got=%0d want=1", strobes - s0); end
  endtask

  task automatic test_extremes;
    radix = 3'd5;
    er = '{-536870912, 536870911, -536870912, 536870911, -536870912};
    ei = '{536870911, -536870912, 536870911, -536870912, 536870911};
    for (int k = 0; k < 5; k++) send(er[k], ei[k], k == 0);
    total++; if (out_val !== 1'b1) begin bad++; $display("FAIL ext_strobe got=%b want=1", out_val); end
    for (int i = 0; i < 5; i++) begin
      total++;
      if (dout_real[i] !== W'(er[i]) || dout_imag[i] !== W'(ei[i])) begin
        bad++; $display("FAIL ext_lane%0d got=%h/%h want=%h/%h", i, dout_real[i], dout_imag[i], W'(er[i]), W'(ei[i]));
      end
    end
    idle(1);
  endtask

  initial begin
    test_reset;
    test_radix3;
    test_radix5_gaps;
    test_radix_change;
    test_resync;
    test_reset_mid;
    test_extremes;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/mrd_rdx_gather.md
# mrd_rdx_gather

Serial-to-lane gather stage that sits directly upstream of the mixed-radix DFT butterflies (radix-2..5). It accepts one complex sample per valid cycle and assembles groups of `radix` consecutive samples. Each completed group is presented as a single 5-lane vector with a one-cycle `out_val` strobe, which matches the lane-array input format of the `mrd_dft_rdx*` stages. Unused lanes are zero-filled, and a start-of-group marker allows resynchronisation.

## Interface
- `wDataInOut`, default 30: sample component width (signed), identical on input and output lanes.
- `clk`  in  1  clock; all logic on rising edge.
- `rst`  in  1  reset. It is synchronous and active-high.
- `in_val`  in  1  input sample valid. Gaps are allowed.
- `in_sop`  in  1  start-of-group. Only meaningful while `in_val`=1.
- `radix`  in  3  group size. Legal values are 2..5; 0, 1, 6 and 7 are coerced to 5. It is sampled only on the first sample of a group.
- `din_real`, `din_imag`  in  `wDataInOut` signed  input sample.
- `out_val`  out  1  one-cycle strobe; the vector is complete.
- `out_radix`  out  3  coerced radix of the emitted group.
- `dout_real[0:4]`, `dout_imag[0:4]`  out  `wDataInOut` signed each  gathered lanes.
- `err_drop`  out  1  one-cycle pulse when a partial group is discarded. Exists only with the macro enabled; see Configuration.

## Operation
- Internal state:
  - lane counter `cnt` (0..4);
  - latched group radix `r_lat`;
  - 5-lane staging registers for real and imag.
- Accepting a sample (`in_val`=1):
  - The sample is written into staging lane `cnt`.
  - If `cnt`==0, `r_lat` is loaded with the coerced `radix`.
  - If `cnt` == `r_lat`-1, the group is complete, and on the next edge:
    - staging lanes 0..`r_lat`-1 are copied to the `dout_*` lanes;
    - lanes `r_lat`..4 of `dout_*` are driven 0;
    - `out_radix` is set to `r_lat`;
    - `out_val` is 1 for exactly one cycle;
    - `cnt` returns to 0.
  - Otherwise `cnt` increments.
- The completing sample goes straight into `dout_*`. There is no extra staging cycle for it.
- `in_val`=0: `cnt`, staging and `r_lat` hold.
- `in_sop`=1 with `in_val`=1:
  - The sample is forced to lane 0 of a new group, `r_lat` reloads, and `cnt` becomes 1. If the coerced `radix` is 1-sample-complete this cannot occur, since the minimum radix is 2.
  - If `cnt`≠0 beforehand, the partial group is discarded and no `out_val` is produced for it.
- `in_sop`=1 with `in_val`=0: ignored.
- A change on `radix` mid-group has no effect until the next group starts.
- Outputs hold the last emitted vector between strobes. Downstream must qualify the data with `out_val` only.
- Back-to-back full-rate input sustains one group per `r_lat` cycles. No backpressure exists.

## Timing
- Latency: the last sample of a group is accepted at edge t; `out_val`=1 and the data are valid in the cycle after edge t+1, i.e. 1-cycle registered latency.
- `err_drop` pulses in the same cycle the discarding `in_sop` sample is registered, that is the cycle after edge t+1.
- Reset, whether at power-up or mid-group:
  - `cnt`=0 and `r_lat`=5;
  - staging and all `dout_*` are 0;
  - `out_radix`=0, `out_val`=0 and `err_drop`=0;
  - any partial group is lost without `err_drop`.
- Reset asserted during the completing sample: reset wins and no strobe is produced.

## Configuration
- `MRD_GATHER_ERR_EN` defined:
  - the `err_drop` port exists;
  - it pulses one cycle for every partial group discarded by `in_sop`.
- Undefined:
  - the port and its detection logic are absent;
  - discard behaviour is otherwise identical.

## Test plan
- **Radix 3, continuous input.** `radix`=3, samples (1,-1),(2,-2),(3,-3) on consecutive cycles with `in_sop` on the first. Required: one `out_val` the cycle after the third sample; lanes 0..2 = (1,-1),(2,-2),(3,-3); lanes 3..4 = 0; `out_radix`=3.
- **Radix 5, gappy input.** `radix`=5, five samples 10..50 with `in_val` low for 2 cycles between each. Required: a single strobe 1 cycle after the 5th sample, lanes = 10,20,30,40,50.
- **Mid-group radix change and coercion.** Start a radix-2 group, change `radix` to 7 after the first sample. Required: the group completes after 2 samples with `out_radix`=2. The next group uses coerced radix 5.
- **Resync discard.** `radix`=4; send 2 samples, then a sample with `in_sop`=1, then 3 more. Required: no strobe for the partial group; `err_drop` pulses once (macro on); the strobe carries the 4 post-sop samples.
- **Reset mid-group.** `rst` high for 1 cycle after 2 of 3 samples, then 3 fresh samples. Required: all outputs 0 during reset; exactly one strobe containing only the fresh samples.
- **Extremes.** Full-scale values -2^29 and 2^29-1 in all 5 lanes. Required: passed bit-exact, with no sign corruption.
